// File: rtl/sn76489_bus_writer.sv
// sn76489_bus_writer
//   Host-side write-port driver for the SN76489 PSG. High-level register
//   commands are queued in a small FIFO. Each one is serialised into the
//   chip's latch/data byte format and strobed onto the PSG bus. The chip's
//   READY handshake is honoured, with a timeout guard on each byte.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   cmd_valid    command offered
//   cmd_ready    FIFO can accept a command (not full)
//   cmd_chan     0-2 tone channel, 3 noise
//   cmd_att      1 = attenuation write, 0 = tone/noise write
//   cmd_value    tone period; attenuation/noise use [3:0]
//   psg_data     byte driven to the PSG
//   psg_we_n     active-low write strobe
//   psg_ready    PSG ready, a write may complete while high
//   busy         FIFO non-empty or a command in flight
//   timeout_err  sticky: some byte write timed out waiting for psg_ready
module sn76489_bus_writer #(
  parameter int FIFO_DEPTH    = 4,
  parameter int WE_CYCLES     = 2,
  parameter int READY_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_chan,
  input  logic       cmd_att,
  input  logic [9:0] cmd_value,
  output logic [7:0] psg_data,
  output logic       psg_we_n,
  input  logic       psg_ready,
  output logic       busy,
  output logic       timeout_err
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (WE_CYCLES > READY_TIMEOUT) ? WE_CYCLES : READY_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(WE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(READY_TIMEOUT - 1);
  localparam logic [PTR_W:0]   FULL_COUNT  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT_RDY, HOLD} state_t;

  typedef struct packed {
    logic [1:0] chan;
    logic       att;
    logic [9:0] value;
  } cmd_t;

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  cmd_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             empty, push, pop;
  cmd_t             head;

  state_t           state, state_next;

  assign empty     = (count == '0);
  assign cmd_ready = (count != FULL_COUNT);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && !empty;
  assign head      = mem[rd_ptr];

  // NOTE: storage has no reset; the count/pointers alone define what is valid,
  // and leaving the array unreset lets it map to plain RAM/regfile cells.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{chan: cmd_chan, att: cmd_att, value: cmd_value};
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;  // wraps modulo FIFO_DEPTH
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] cnt;          // clocks spent in STROBE / WAIT_RDY
  logic             data_pending; // second (data) byte still to send
  logic [7:0]       data_byte;
  logic             wait_expired;

  assign wait_expired = (cnt == WAIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (!empty) state_next = SETUP;
      SETUP:    state_next = STROBE;
      STROBE:   if (cnt == STROBE_LAST) state_next = WAIT_RDY;
      WAIT_RDY: if (psg_ready || wait_expired) state_next = HOLD;
      HOLD:     state_next = data_pending ? SETUP : IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    psg_we_n = !((state == STROBE) || (state == WAIT_RDY));
    busy     = !empty || (state != IDLE);
  end

  // Latch byte for the FIFO head. Noise control only has 3 meaningful bits,
  // so bit 3 is forced clear there; noise attenuation keeps all 4 bits.
  logic [3:0] latch_lo;
  assign latch_lo = (head.chan == 2'd3 && !head.att) ? {1'b0, head.value[2:0]}
                                                     : head.value[3:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      psg_data     <= 8'h00;
      data_byte    <= 8'h00;
      data_pending <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      // The counter restarts on every state change so STROBE and WAIT_RDY
      // each measure their own dwell from zero.
      if (state_next != state || !(state == STROBE || state == WAIT_RDY))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (pop) begin
        psg_data     <= {1'b1, head.chan, head.att, latch_lo};
        data_byte    <= {2'b00, head.value[9:4]};
        data_pending <= !head.att && (head.chan != 2'd3);
      end else if (state == HOLD && data_pending) begin
        psg_data     <= data_byte;
        data_pending <= 1'b0;
      end

      // A timed-out byte abandons the rest of its command.
      if (state == WAIT_RDY && !psg_ready && wait_expired) begin
        timeout_err  <= 1'b1;
        data_pending <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sn76489_bus_writer.md
Name: sn76489_bus_writer

Overview:
Host-side driver for the SN76489 PSG write port. It accepts high-level register commands (tone period, attenuation, noise control) through a valid/ready interface and buffers them in a small FIFO. It serializes each command into the 1- or 2-byte SN76489 latch/data byte format. It drives the PSG's 8-bit data bus with an active-low write strobe and honours the chip's READY handshake. It sits between a sequencer/CPU block and the PSG core in player and test designs.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
WE_CYCLES, 2, clocks psg_we_n is held low per byte (>=1)
READY_TIMEOUT, 255, max clocks to wait for psg_ready before abort (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept (not full)
cmd_chan  in  2  channel 0-2 tone, 3 noise
cmd_att  in  1  1=attenuation write, 0=tone/noise write
cmd_value  in  10  tone period; attenuation/noise use [3:0]
psg_data  out  8  byte to PSG
psg_we_n  out  1  active-low write strobe
psg_ready  in  1  PSG ready (high = may complete write)
busy  out  1  FIFO non-empty or FSM not IDLE
timeout_err  out  1  sticky: a byte write timed out; cleared only by rst

Behaviour:
- Reset (async, any state):
  - FIFO emptied; FSM -> IDLE.
  - psg_data=8'h00, psg_we_n=1, busy=0, timeout_err=0.
  - cmd_ready=1 from the first clock after reset deasserts.
  - A partially written command is dropped.
- Command accept: a command is pushed when cmd_valid && cmd_ready at the rising edge.
  - cmd_ready = !full (combinational from FIFO count). No bypass path.
  - A push while full is impossible by construction.
  - Simultaneous push and pop while full is not accepted; cmd_ready is already low.
- Byte encoding:
  - Latch byte = {1, cmd_chan, cmd_att, cmd_value[3:0]}.
  - Data byte = {0, 0, cmd_value[9:4]}.
  - Two bytes (latch then data) only when cmd_att=0 and cmd_chan!=3. Otherwise the latch byte only.
  - For noise, cmd_value[3] is ignored and forced to 0 in the latch byte.
- FSM states: IDLE, SETUP, STROBE, WAIT_RDY, HOLD.
  - IDLE: if FIFO non-empty, pop the head into the command register, drive the latch byte on psg_data, go to SETUP. The pop is visible on the next cycle's FIFO count.
  - SETUP (1 clk): psg_we_n=1, data stable. Go to STROBE.
  - STROBE: psg_we_n=0 for exactly WE_CYCLES clocks (counter), then go to WAIT_RDY.
  - WAIT_RDY: psg_we_n stays 0.
    - If psg_ready=1, go to HOLD.
    - If the wait counter reaches READY_TIMEOUT clocks without ready, set timeout_err, abandon the remaining bytes of the command, and go to HOLD.
  - HOLD (1 clk): psg_we_n=1, psg_data held.
    - If a data byte is pending, load it on psg_data and go to SETUP.
    - Otherwise go to IDLE.
- psg_data changes only on entry to SETUP, never while psg_we_n=0.
- If psg_ready is already high on the first WAIT_RDY clock, the write completes in 1 clock. Minimum byte cost = 1 + WE_CYCLES + 1 + 1 clocks.
- Back-to-back commands: IDLE is entered for 1 clock between commands. No bytes of different commands interleave.
- FIFO pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.

Test Plan:
- Reset with defaults -> psg_we_n=1, psg_data=0x00, busy=0, cmd_ready=1, timeout_err=0.
- Push chan=1, att=0, value=0x2A5, psg_ready tied 1 -> bus writes 0xA5 then 0x2A. Each byte has psg_we_n low exactly 3 clocks (2 STROBE + 1 WAIT_RDY). Back to IDLE 10 clocks after the pop.
- Push att chan=2 value=0x7, then noise chan=3 value=0xC -> single writes 0xD7, then 0xE4 (bit3 forced 0).
- Hold psg_ready=0 for 20 clocks during a tone write -> psg_we_n stays low, data stable. Completes 1 clock after psg_ready rises. timeout_err stays 0.
- psg_ready stuck 0 with READY_TIMEOUT=8 -> timeout_err=1 after 8 WAIT_RDY clocks. The data byte is skipped and the next queued command is written normally.
- Push 6 commands back-to-back with psg_ready=0 -> cmd_ready drops after 5 accepts (4 queued + 1 popped). Release ready: all accepted commands are written in order. Assert rst mid-STROBE -> psg_we_n=1 and busy=0 immediately (asynchronous).
